core_dispatch_arb: RTL
======================

# core_dispatch_arb

Sits between the task scheduler and the shader cores. It accepts one task header at a time (core mask, r0 init vector, fence, instruction-frame count) and gates dispatch on core occupancy and fence rules. It then sequences the header and instruction words onto the shared 16-bit core message bus with the matching load strobes. It owns the authoritative per-core busy mask, which is set on dispatch and cleared by core completion pulses.

## Interface
- CORE_NUM, 16, number of cores; also width of mask/r0 words
- MSG_WIDTH, 16, core message bus width; must equal CORE_NUM
- WORDS_PER_IF, 16, instruction words per instruction frame
- IFNUM_W, 6, width of frame count
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- hdr_valid  in  1  task header valid
- hdr_ready  out  1  header consumed this cycle
- hdr_mask  in  CORE_NUM  cores used by task
- hdr_r0  in  CORE_NUM  r0 init vector
- hdr_fence  in  2  fence code
- hdr_if_num  in  IFNUM_W  instruction frames in task
- word_valid  in  1  instruction word valid
- word_ready  out  1  instruction word accepted
- word_data  in  MSG_WIDTH  instruction word
- core_reading  in  1  cores sample bus this cycle
- core_done  in  CORE_NUM  one-cycle completion pulse per core
- mess_to_core  out  MSG_WIDTH  message bus
- mess_valid  out  1  bus word valid
- core_mask_loading, r0_loading, if_loading  out  1 each  word-type strobes
- busy_mask  out  CORE_NUM  cores currently executing

## Operation
- Fence codes: NONE=0, ACQ=1, REL=2, 3 is reserved and treated as NONE.
- FSM states: IDLE, GATE, MASK, R0, IF.
- IDLE: if hdr_valid, go to GATE.
- GATE: dispatch when all of the following hold: (hdr_mask & busy_mask)==0; fence≠REL or busy_mask==0; acq_mask & busy_mask==0. When they hold, go to MASK; otherwise stay in GATE. Header fields must stay stable while hdr_valid is high.
- MASK: mess_to_core=hdr_mask, mess_valid=1, core_mask_loading=1. On core_reading:
  - hdr_ready pulses for 1 cycle.
  - Header is latched internally (r0, if_num).
  - busy_mask |= hdr_mask.
  - If fence==ACQ, acq_mask<=hdr_mask; otherwise acq_mask is unchanged.
  - Next state is R0.
- R0: mess_to_core=latched r0, r0_loading=1, mess_valid=1. On core_reading: if if_num==0 go to IDLE; otherwise load word counter = if_num*WORDS_PER_IF and go to IF.
- IF: word_ready=core_reading; mess_to_core=word_data; mess_valid=word_valid; if_loading=1. Each word_valid&core_reading decrements the counter. When the counter goes 1→0, go to IDLE.
- Busy update every cycle: busy_next=(busy & ~core_done) | set_mask.
  - set wins over done for the same core in the same cycle.
  - done on an idle core is ignored.
- acq_mask clears to 0 when (acq_mask & busy_mask)==0.
- Word counter width is IFNUM_W+clog2(WORDS_PER_IF) bits, so the maximum of 63*16=1008 words fits without wrap.
- Outputs not listed for a state are 0.

## Timing
- Reset (async, reset low): state=IDLE, busy_mask=0, acq_mask=0, counter=0. All outputs are 0, including mess_to_core.
- Reset mid-task aborts the task immediately. No partial state survives, and in-flight words are not consumed.
- mess_to_core, mess_valid, strobes, hdr_ready and word_ready are combinational from state and registered header. word_data passes through combinationally in IF.
- Latency from hdr_valid rising in IDLE with no conflicts: GATE at +1, MASK on bus at +2. With core_reading held high, R0 is at +3 and the first IF word at +4.
- core_reading low stalls all states in place, with bus contents held.
- busy_mask reflects a dispatch on the cycle after the MASK transfer. A core_done pulse takes effect on the next cycle, so a task gated in GATE can proceed at the earliest 1 cycle after the clearing pulse.
- Back-to-back tasks: IDLE costs 1 cycle between tasks.

## Structure
- Fence codes, state encoding and MSG_WIDTH default live in gpu_def.v as `defines (SCHED_FENCE_NONE/ACQ/REL already exist there; add SCHED_DISP_* state codes).
- Sub-module core_busy_tracker holds busy_mask and acq_mask.
  - Inputs: set_mask, set_acq, core_done.
  - Outputs: busy_mask, acq_clear.
- FSM and word counter stay in the top module.

## Test plan
- hdr mask=0x0003, r0=0x0001, fence NONE, if_num=1, core_reading=1, words 0x1000..0x100F → bus shows 0x0003 (mask strobe), 0x0001 (r0 strobe), then 16 words with if_loading; busy_mask=0x0003; return to IDLE.
- busy=0x0001, next hdr mask=0x0001 → held in GATE. core_done[0] pulse → MASK on bus 1 cycle later; busy=0x0001 again.
- REL task mask=0x0010 while busy=0x0002 → waits until core_done[1], then dispatches.
- ACQ task mask=0x0004, then NONE task mask=0x0008 → second task waits in GATE until core_done[2] clears acq_mask.
- core_reading toggled 1/0 during IF with word_valid gaps, if_num=2 → exactly 32 words transferred, none duplicated or dropped.
- Simultaneous core_done[0] and dispatch of mask=0x0001 → busy[0] stays 1. reset low mid-IF → all outputs 0 and busy=0 asynchronously.

Source files
------------

// File: rtl/core_dispatch_arb_pkg.sv
// Shared fence codes, dispatch FSM states and default widths for the
// core dispatch arbiter.
package core_dispatch_arb_pkg;

  localparam int unsigned DISP_CORE_NUM  = 16;
  localparam int unsigned DISP_MSG_WIDTH = 16;

  typedef enum logic [1:0] {
    FENCE_NONE = 2'd0,
    FENCE_ACQ  = 2'd1,
    FENCE_REL  = 2'd2,
    FENCE_RSVD = 2'd3
  } fence_e;

  typedef enum logic [2:0] {
    DISP_IDLE,
    DISP_GATE,
    DISP_MASK,
    DISP_R0,
    DISP_IF
  } disp_state_e;

endpackage

// File: rtl/core_dispatch_arb_busy_tracker.sv
// Authoritative per-core busy mask plus the outstanding acquire-fence mask.
// A set in the same cycle as a completion pulse keeps the core busy.
import core_dispatch_arb_pkg::*;

module core_busy_tracker #(
  parameter int unsigned CORE_NUM = DISP_CORE_NUM
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CORE_NUM-1:0] set_mask,
  input  logic                set_acq,
  input  logic [CORE_NUM-1:0] core_done,
  output logic [CORE_NUM-1:0] busy_mask,
  output logic                acq_clear
);

  logic [CORE_NUM-1:0] r_busy;
  logic [CORE_NUM-1:0] r_acq;

  assign acq_clear = (r_acq & r_busy) == '0;
  assign busy_mask = r_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
      r_acq  <= '0;
    end else begin
      r_busy <= (r_busy & ~core_done) | set_mask;
      // A new acquire replaces the old one; it can only dispatch once the old one drained.
      if (set_acq)
        r_acq <= set_mask;
      else if (acq_clear)
        r_acq <= '0;
    end
  end

endmodule

// File: rtl/core_dispatch_arb.sv
// Task dispatch arbiter: gates task headers on core occupancy and fences,
// then sequences mask, r0 and instruction words onto the core message bus.
import core_dispatch_arb_pkg::*;

module core_dispatch_arb #(
  parameter int unsigned CORE_NUM     = DISP_CORE_NUM,
  parameter int unsigned MSG_WIDTH    = DISP_MSG_WIDTH,
  parameter int unsigned WORDS_PER_IF = 16,
  parameter int unsigned IFNUM_W      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hdr_valid,
  output logic                 hdr_ready,
  input  logic [CORE_NUM-1:0]  hdr_mask,
  input  logic [CORE_NUM-1:0]  hdr_r0,
  input  logic [1:0]           hdr_fence,
  input  logic [IFNUM_W-1:0]   hdr_if_num,
  input  logic                 word_valid,
  output logic                 word_ready,
  input  logic [MSG_WIDTH-1:0] word_data,
  input  logic                 core_reading,
  input  logic [CORE_NUM-1:0]  core_done,
  output logic [MSG_WIDTH-1:0] mess_to_core,
  output logic                 mess_valid,
  output logic                 core_mask_loading,
  output logic                 r0_loading,
  output logic                 if_loading,
  output logic [CORE_NUM-1:0]  busy_mask
);

  localparam int unsigned CNT_W = IFNUM_W + $clog2(WORDS_PER_IF);

  disp_state_e         r_state;
  disp_state_e         w_state_nxt;
  logic [CORE_NUM-1:0] r_r0;
  logic [IFNUM_W-1:0]  r_if_num;
  logic [CNT_W-1:0]    r_cnt;
  logic [CORE_NUM-1:0] w_set_mask;
  logic                w_set_acq;
  logic                w_acq_clear;
  logic                w_gate_ok;
  logic                w_word_xfer;
  fence_e              w_fence;

  assign w_fence     = fence_e'(hdr_fence);
  assign w_gate_ok   = ((hdr_mask & busy_mask) == '0)
                     && ((w_fence != FENCE_REL) || (busy_mask == '0))
                     && w_acq_clear;
  assign w_word_xfer = (r_state == DISP_IF) && word_valid && core_reading;

  core_busy_tracker #(.CORE_NUM(CORE_NUM)) u_busy (
    .clk       (clk),
    .reset     (reset),
    .set_mask  (w_set_mask),
    .set_acq   (w_set_acq),
    .core_done (core_done),
    .busy_mask (busy_mask),
    .acq_clear (w_acq_clear)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= DISP_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_r0     <= '0;
      r_if_num <= '0;
      r_cnt    <= '0;
    end else begin
      if (r_state == DISP_MASK && core_reading) begin
        r_r0     <= hdr_r0;
        r_if_num <= hdr_if_num;
      end
      if (r_state == DISP_R0 && core_reading)
        r_cnt <= CNT_W'(r_if_num) * CNT_W'(WORDS_PER_IF);
      else if (w_word_xfer)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    hdr_ready         = 1'b0;
    word_ready        = 1'b0;
    mess_to_core      = '0;
    mess_valid        = 1'b0;
    core_mask_loading = 1'b0;
    r0_loading        = 1'b0;
    if_loading        = 1'b0;
    w_set_mask        = '0;
    w_set_acq         = 1'b0;
    case (r_state)
      DISP_IDLE: if (hdr_valid) w_state_nxt = DISP_GATE;
      DISP_GATE: if (w_gate_ok) w_state_nxt = DISP_MASK;
      DISP_MASK: begin
        mess_to_core      = hdr_mask;
        mess_valid        = 1'b1;
        core_mask_loading = 1'b1;
        if (core_reading) begin
          hdr_ready   = 1'b1;
          w_set_mask  = hdr_mask;
          w_set_acq   = (w_fence == FENCE_ACQ);
          w_state_nxt = DISP_R0;
        end
      end
      DISP_R0: begin
        mess_to_core = r_r0;
        mess_valid   = 1'b1;
        r0_loading   = 1'b1;
        if (core_reading)
          w_state_nxt = (r_if_num == '0) ? DISP_IDLE : DISP_IF;
      end
      DISP_IF: begin
        word_ready   = core_reading;
        mess_to_core = word_data;
        mess_valid   = word_valid;
        if_loading   = 1'b1;
        if (w_word_xfer && r_cnt == CNT_W'(1))
          w_state_nxt = DISP_IDLE;
      end
      default: w_state_nxt = DISP_IDLE;
    endcase
  end

endmodule
